// File: rtl/alu_result_bcd.sv
// alu_result_bcd: decodes the opcode-specific packing of the ALU result, then converts the
// magnitude to three BCD digits with a sequential double-dabble engine.
// Results leave through a valid/ready handshake.
module alu_result_bcd #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y_in,
    input  logic [1:0]   op_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   bcd_hund,
    output logic [3:0]   bcd_tens,
    output logic [3:0]   bcd_ones,
    output logic         neg,
    output logic         half,
    output logic [1:0]   op_out
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              neg_q, neg_d;
    logic              half_q, half_d;
    logic [1:0]        op_q, op_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_shift;
    logic [W-1:0]      mag_shift;

    // One double-dabble step: add 3 to any digit >= 5, then shift {bcd, mag} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BcdW-2:0], mag_q[W-1]};
        mag_shift = {mag_q[W-2:0], 1'b0};
    end

    // Next-state logic: accept/decode in idle, iterate in shift, hold until handshake in done.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        neg_d   = neg_q;
        half_d  = half_q;
        op_d    = op_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        unique case (state_q)
            StIdle: begin
                // op_in is only looked at under in_valid so an unknown opcode cannot leak in.
                if (in_valid) begin
                    bcd_d   = '0;
                    count_d = CntW'(W);
                    op_d    = op_in;
                    neg_d   = 1'b0;
                    half_d  = 1'b0;
                    case (op_in)
                        2'b00: mag_d = W'(y_in[4:0]);
                        2'b01: begin
                            mag_d = W'(y_in[3:0]);
                            // No negative zero.
                            neg_d = y_in[7] & (y_in[3:0] != 4'd0);
                        end
                        2'b10: mag_d = y_in;
                        default: begin
                            mag_d  = W'(y_in[3:0]);
                            half_d = y_in[7];
                        end
                    endcase
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d   = bcd_shift;
                mag_d   = mag_shift;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    hund_d  = bcd_shift[11:8];
                    tens_d  = bcd_shift[7:4];
                    ones_d  = bcd_shift[3:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            half_q  <= 1'b0;
            op_q    <= 2'b00;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            half_q  <= half_d;
            op_q    <= op_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    // Handshake flags follow the state directly; data outputs come straight from registers.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        bcd_hund  = hund_q;
        bcd_tens  = tens_q;
        bcd_ones  = ones_q;
        neg       = neg_q;
        half      = half_q;
        op_out    = op_q;
    end

endmodule

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd: directed cases plus randomized results checked
// against an arithmetic reference model of the decode and decimal conversion.
module tb_alu_result_bcd;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y_in;
    logic [1:0] op_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       neg;
    logic       half;
    logic [1:0] op_out;

    int n_tests;
    int n_fail;

    alu_result_bcd #(
        .W      (8),
        .DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .op_in     (op_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .neg       (neg),
        .half      (half),
        .op_out    (op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: decode to a magnitude with plain arithmetic, then split into decimal
    // digits. Result packs {hund, tens, ones, neg, half, op}.
    function automatic logic [15:0] model(input logic [7:0] y, input logic [1:0] op);
        int m;
        logic n;
        logic h;
        n = 1'b0;
        h = 1'b0;
        case (op)
            2'b00: m = y % 32;
            2'b01: begin
                m = y % 16;
                n = (y >= 128) && (m != 0);
            end
            2'b10: m = y;
            default: begin
                m = y % 16;
                h = (y >= 128);
            end
        endcase
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10), n, h, op};
    endfunction

    function automatic logic [15:0] observed();
        return {bcd_hund, bcd_tens, bcd_ones, neg, half, op_out};
    endfunction

    // Counts edges after the accept edge until out_valid; returns the count (capped).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction: accept, check latency and result, hold under backpressure, drain.
    task automatic run_one(input logic [7:0] y, input logic [1:0] op, input int hold);
        logic [15:0] exp;
        int          lat;
        int          k;
        exp = model(y, op);
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("ready_before_accept", in_ready, 1);
        y_in     = y;
        op_in    = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        y_in     = 8'($urandom);
        op_in    = 2'($urandom);
        check_eq("in_ready_low_in_shift", in_ready, 0);
        wait_valid(lat);
        check_eq("latency", lat, 8);
        check_eq($sformatf("result y=%02h op=%0d", y, op), observed(), exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_stable", {out_valid, in_ready, observed()}, {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("drain_to_idle", {out_valid, in_ready, observed()}, {1'b0, 1'b1, exp});
    endtask

    initial begin
        logic [15:0] exp;
        int          lat;
        int          pulses;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y_in      = 8'h00;
        op_in     = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {out_valid, observed()}, 17'd0);
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_after_reset", in_ready, 1);

        // Directed cases.
        run_one(8'h11, 2'b00, 0);
        run_one(8'h84, 2'b01, 1);
        run_one(8'h80, 2'b01, 0);
        run_one(8'hE1, 2'b10, 0);
        run_one(8'h87, 2'b11, 2);

        // Backpressure: a second request presented during done must wait for idle.
        run_one(8'hE1, 2'b10, 0);
        y_in     = 8'hE1;
        op_in    = 2'b10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check_eq("bp_latency", lat, 8);
        y_in     = 8'h11;
        op_in    = 2'b00;
        in_valid = 1'b1;
        exp = model(8'hE1, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold", {out_valid, in_ready, observed()}, {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_back_to_idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_second_accepted", in_ready, 0);
        wait_valid(lat);
        check_eq("bp_second_latency", lat, 8);
        check_eq("bp_second_result", observed(), model(8'h11, 2'b00));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of the shift phase.
        y_in     = 8'h87;
        op_in    = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_shift_reset_outputs", {out_valid, observed()}, 17'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_after_mid_reset", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check_eq("no_valid_after_reset", pulses, 0);

        // Randomized results and backpressure lengths.
        for (int i = 0; i < 40; i++) begin
            run_one(8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
